// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data memory that answers CPU memory-stage loads and stores.
//   clk        : single clock, rising edge
//   reset      : asynchronous active-low reset
//   req_valid  : request present
//   req_we     : 1 = store, 0 = load
//   req_addr   : byte address; word index is addr[DEPTH_LOG2+1:2]
//   req_wdata  : store data
//   req_ready  : request can be accepted this cycle
//   stall      : inverse of req_ready, holds the CPU pipeline
//   resp_valid : one-cycle response strobe
//   resp_rdata : load data, held between responses
//   resp_err   : misaligned access, only during resp_valid
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t                  state;
    logic [3:0]              cnt;
    logic                    lat_we;
    logic [DEPTH_LOG2+1:0]   lat_addr;
    logic [31:0]             lat_wdata;
    logic [31:0]             mem [2**DEPTH_LOG2];
    logic                    accept;
    logic                    from_busy;
    logic                    enter_resp;
    logic                    acc_we;
    logic [DEPTH_LOG2+1:0]   acc_addr;
    logic [31:0]             acc_wdata;
    logic                    aligned;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    unused_addr;
    assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];
    assign req_ready   = state != BUSY;
    assign stall       = ~req_ready;
    assign resp_valid  = state == RESP;
    assign accept      = req_valid && req_ready;
    assign from_busy   = state == BUSY;
    // With LATENCY=1 the access happens on the accepting edge, so it uses the live request.
    assign enter_resp  = from_busy ? cnt == 4'd1 : accept && LATENCY == 1;
    assign acc_we      = from_busy ? lat_we : req_we;
    assign acc_addr    = from_busy ? lat_addr : req_addr[DEPTH_LOG2+1:0];
    assign acc_wdata   = from_busy ? lat_wdata : req_wdata;
    assign aligned     = acc_addr[1:0] == 2'b00;
    assign idx         = acc_addr[DEPTH_LOG2+1:2];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_err <= enter_resp && !aligned;
            if (enter_resp)
                resp_rdata <= (!acc_we && aligned) ? mem[idx] : '0;
            if (from_busy) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1)
                    state <= RESP;
            end else if (accept) begin
                state     <= LATENCY == 1 ? RESP : BUSY;
                cnt       <= 4'(LATENCY - 1);
                lat_we    <= req_we;
                lat_addr  <= req_addr[DEPTH_LOG2+1:0];
                lat_wdata <= req_wdata;
            end else begin
                state <= IDLE;
            end
        end
    end
    // Array is never cleared; gating on reset drops any access while reset is held.
    always_ff @(posedge clk)
        if (reset && enter_resp && acc_we && aligned)
            mem[idx] <= acc_wdata;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 8; the word array holds 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter: LATENCY, default 2; cycles from request acceptance to response, legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; low clears all control state immediately.
REQ-005 Port: req_valid  input  1  CPU memory-stage request present.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_addr  input  32  byte address.
REQ-008 Port: req_wdata  input  32  store data.
REQ-009 Port: req_ready  output  1  responder can accept a request this cycle.
REQ-010 Port: stall  output  1  equal to NOT req_ready; drives the CPU pipeline hold.
REQ-011 Port: resp_valid  output  1  one-cycle response strobe.
REQ-012 Port: resp_rdata  output  32  load data, qualified by resp_valid.
REQ-013 Port: resp_err  output  1  misaligned-access flag, qualified by resp_valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-015 req_ready SHALL be 1 in IDLE and RESP, and 0 in BUSY.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-017 On acceptance, the block SHALL latch req_we, req_addr and req_wdata, and load the latency counter with LATENCY-1.
REQ-018 Request inputs SHALL be ignored on every edge where no acceptance occurs.
REQ-019 On acceptance with LATENCY=1, the FSM SHALL go directly to RESP; otherwise it SHALL go to BUSY.
REQ-020 In BUSY, the counter SHALL decrement each edge; the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-021 resp_valid SHALL be high for exactly one cycle (the RESP state), beginning exactly LATENCY edges after the accepting edge.
REQ-022 The array access for a transaction SHALL occur on the edge that enters RESP; writes update the array, and reads register the word into resp_rdata.
REQ-023 The word index SHALL be the latched address bits [DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 2^(DEPTH_LOG2+2).
REQ-024 If latched addr[1:0] != 0: no array write, resp_rdata=0, and resp_err=1 during RESP.
REQ-025 For stores, resp_rdata SHALL be 0 during RESP.
REQ-026 resp_err SHALL be 0 whenever resp_valid=0.
REQ-027 resp_rdata SHALL hold its last value while resp_valid=0.
REQ-028 From RESP: if a new request is accepted on the same edge, the FSM SHALL follow REQ-019; otherwise it SHALL return to IDLE. This allows back-to-back transactions with no idle gap.
REQ-029 A load to the same word as an immediately preceding store SHALL return the stored data (store commits before the load's access edge).

Reset
REQ-030 While reset=0, the block SHALL be in IDLE with req_ready=1, stall=0, resp_valid=0, resp_rdata=0, resp_err=0 and counter=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction, and a pending store SHALL NOT be written.
REQ-032 Array contents SHALL NOT be cleared by reset.
REQ-033 The first acceptance SHALL be possible on the first rising edge after reset goes high.

Verification
REQ-034 LATENCY=2: store addr 0x0000_0010, data 0xDEAD_BEEF -> stall=1 for 1 cycle, resp_valid=1 in the 2nd cycle with rdata=0, err=0; then a load of 0x10 returns 0xDEAD_BEEF two edges after its acceptance.
REQ-035 Back-to-back: store 0x20=0x1234_5678, with the load of 0x20 presented during RESP -> load accepted in the same cycle with no IDLE gap, and the load returns 0x1234_5678.
REQ-036 Wrap: DEPTH_LOG2=8; store 0x0000_0404=0xA5A5_A5A5 -> a load of 0x0000_0004 returns 0xA5A5_A5A5.
REQ-037 Misaligned: store 0x0000_0032=0xFFFF_FFFF -> resp_err=1 and rdata=0; a subsequent load of 0x30 returns its prior value unchanged.
REQ-038 Reset mid-BUSY: LATENCY=4, store 0x40=0x5555_5555, reset pulsed low in cycle 2 -> outputs go to reset values immediately, no resp_valid, and a load of 0x40 returns the old contents.
REQ-039 LATENCY=1: a stream of 4 loads with req_valid held high -> resp_valid high every cycle after the first, and stall=0 throughout.
